// File: rtl/ahb_uart_dbg_master_pkg.sv
// Shared definitions for the UART-to-AHB-lite debug bridge: command and
// response bytes, AHB encodings and the state enums of the bridge FSMs.
package ahb_uart_dbg_master_pkg;

    // Frame command bytes and response bytes
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    // AHB-lite encodings used by a single-word master
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    // Command FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_ADDR,
        ST_WDATA,
        ST_BUS_A,
        ST_BUS_D,
        ST_RESP
    } cmd_state_e;

    // UART receiver states; RX_BREAK waits for the line to return high
    // after a framing error so the still-low stop bit is not taken as a
    // new start bit.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_8n1.sv
// 8N1 UART, LSB first: receiver with 2-flop synchronizer, mid-bit sampling
// and glitch/framing rejection, plus a transmitter that holds each bit for
// exactly CLKS_PER_BIT cycles.
module uart_8n1
    import ahb_uart_dbg_master_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       rxd,
    output logic       txd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_idle
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic             rxd_meta;
    logic             rxd_sync;
    rx_state_e        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;

    logic             tx_active;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [9:0]       tx_shift;

    assign tx_idle = !tx_active;

    // Bring the asynchronous rxd pin into the HCLK domain (idle level is 1)
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // Receiver: confirm start at half a bit, then sample each bit centre
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rxd_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxd_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rxd_sync) begin
                            rx_valid <= 1'b1;
                            rx_data  <= rx_shift;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_BREAK;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_BREAK: begin
                    if (rxd_sync) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Transmitter: shift out {stop, data, start}, one bit per CLKS_PER_BIT
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            txd       <= 1'b1;
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '1;
        end else if (!tx_active) begin
            if (tx_start) begin
                tx_shift  <= {1'b1, tx_data, 1'b0};
                txd       <= 1'b0;
                tx_cnt    <= '0;
                tx_bit    <= '0;
                tx_active <= 1'b1;
            end
        end else if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_active <= 1'b0;
                txd       <= 1'b1;
            end else begin
                tx_bit   <= tx_bit + 4'd1;
                tx_shift <= {1'b1, tx_shift[9:1]};
                txd      <= tx_shift[1];
            end
        end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/ahb_uart_dbg_master.sv
// UART-to-AHB-lite debug bridge. Parses read/write frames from the UART,
// performs one single-word AHB-lite transfer as bus master and returns the
// read data or a status byte on txd.
module ahb_uart_dbg_master
    import ahb_uart_dbg_master_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 87,
    parameter int          TIMEOUT_CYC  = 20000,
    parameter logic [7:0]  ADDR_HI      = 8'h00
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        rxd,
    output logic        txd,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP,
    output logic        busy
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    cmd_state_e      state;
    logic            is_write;
    logic [1:0]      byte_cnt;
    logic [1:0]      resp_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [23:0]     addr_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            tx_sent;

    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_idle;

    // Word aligned: the two low address bits received are discarded
    assign HADDR  = {ADDR_HI, addr_q[23:2], 2'b00};
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_DATA;
    assign busy   = (state != ST_IDLE);

    logic unused_ok;
    assign unused_ok = &{1'b0, HRESP[1], addr_q[1:0]};

    uart_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .rxd      (rxd),
        .txd      (txd),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_idle  (tx_idle)
    );

    // Command FSM: frame parsing, inter-byte timeout, AHB beat, response
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            is_write <= 1'b0;
            byte_cnt <= '0;
            resp_cnt <= '0;
            to_cnt   <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tx_sent  <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            HTRANS   <= HTRANS_IDLE;
            HWRITE   <= 1'b0;
            HWDATA   <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                        is_write <= (rx_data == CMD_WR);
                        byte_cnt <= '0;
                        to_cnt   <= '0;
                        state    <= ST_CMD_ADDR;
                    end
                end
                ST_CMD_ADDR: begin
                    if (rx_valid) begin
                        addr_q <= {addr_q[15:0], rx_data};
                        to_cnt <= '0;
                        if (byte_cnt == 2'd2) begin
                            byte_cnt <= '0;
                            if (is_write) begin
                                state <= ST_WDATA;
                            end else begin
                                state  <= ST_BUS_A;
                                HTRANS <= HTRANS_NONSEQ;
                                HWRITE <= 1'b0;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end
                ST_WDATA: begin
                    if (rx_valid) begin
                        HWDATA <= {HWDATA[23:0], rx_data};
                        to_cnt <= '0;
                        if (byte_cnt == 2'd3) begin
                            state  <= ST_BUS_A;
                            HTRANS <= HTRANS_NONSEQ;
                            HWRITE <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end
                ST_BUS_A: begin
                    if (HREADY) begin
                        HTRANS <= HTRANS_IDLE;
                        HWRITE <= 1'b0;
                        state  <= ST_BUS_D;
                    end
                end
                ST_BUS_D: begin
                    if (HREADY) begin
                        rdata_q  <= HRDATA;
                        err_q    <= HRESP[0];
                        resp_cnt <= '0;
                        tx_sent  <= 1'b0;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // tx_start is still high on the cycle the UART takes it,
                    // so tx_idle only means "byte done" once tx_start is low.
                    if (!tx_sent) begin
                        if (tx_idle) begin
                            tx_start <= 1'b1;
                            tx_sent  <= 1'b1;
                            tx_data  <= err_q    ? RSP_ERR :
                                        is_write ? RSP_OK  : rdata_q[31:24];
                        end
                    end else if (!tx_start && tx_idle) begin
                        tx_sent <= 1'b0;
                        if (err_q || is_write || resp_cnt == 2'd3) begin
                            state <= ST_IDLE;
                        end else begin
                            resp_cnt <= resp_cnt + 2'd1;
                            rdata_q  <= {rdata_q[23:0], 8'h00};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
